// File: rtl/find_corners_scan.sv
// Scans one row and one column of a frame buffer through the center point and
// reports the extent of the "on" run that contains the center on each axis.

module find_corners_run_track #(
    parameter int IW      = 8,
    parameter int GAP_TOL = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clr,
    input  logic          en,
    input  logic          pix_on,
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] center,
    output logic [IW-1:0] lo_nxt,
    output logic [IW-1:0] hi_nxt,
    output logic          found_nxt
);
    localparam int OW = $clog2(GAP_TOL + 2);

    logic          run_q, run_d, in_c_q, in_c_d, found_q;
    logic [OW-1:0] off_q, off_d;
    logic [IW-1:0] start_q, start_d, lo_q, hi_q;

    // Next values are exposed so the final pixel can land in the same edge
    // that publishes results.
    always_comb begin
        run_d     = run_q;
        in_c_d    = in_c_q;
        off_d     = off_q;
        start_d   = start_q;
        lo_nxt    = lo_q;
        hi_nxt    = hi_q;
        found_nxt = found_q;
        if (en) begin
            if (pix_on) begin
                off_d = '0;
                if (!run_q) begin
                    start_d = idx;
                    run_d   = 1'b1;
                end
            end else begin
                if (off_q <= OW'(GAP_TOL)) off_d = off_q + OW'(1);
                if (off_d > OW'(GAP_TOL)) run_d = 1'b0;
            end
            if (idx == center) begin
                if (pix_on) begin
                    lo_nxt    = start_d;
                    hi_nxt    = center;
                    found_nxt = 1'b1;
                    in_c_d    = 1'b1;
                end else begin
                    lo_nxt    = center;
                    hi_nxt    = center;
                    found_nxt = 1'b0;
                    in_c_d    = 1'b0;
                end
            end else if (in_c_q) begin
                if (pix_on) hi_nxt = idx;
                else if (!run_d) in_c_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            run_q   <= 1'b0;
            in_c_q  <= 1'b0;
            off_q   <= '0;
            start_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            found_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            in_c_q  <= in_c_d;
            off_q   <= off_d;
            start_q <= start_d;
            lo_q    <= lo_nxt;
            hi_q    <= hi_nxt;
            found_q <= found_nxt;
        end
    end
endmodule

module find_corners_scan #(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int READ_LATENCY = 2,
    parameter int GAP_TOL      = 0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          find_corners_flag,
    input  logic [XW-1:0] x_center,
    input  logic [YW-1:0] y_center,
    input  logic [1:0]    chan_sel,
    input  logic [5:0]    threshold,
    input  logic [15:0]   pixel_data_in,
    output logic [AW-1:0] addr_out,
    output logic          busy_out,
    output logic          data_valid_out,
    output logic [XW-1:0] left_edge,
    output logic [XW-1:0] right_edge,
    output logic [YW-1:0] top_edge,
    output logic [YW-1:0] bot_edge,
    output logic          found_x,
    output logic          found_y
);
    localparam int IW = (XW > YW) ? XW : YW;
    localparam int CW = (IW > 3) ? IW : 3;
    localparam logic [AW-1:0] W_A = AW'(WIDTH);

    typedef enum logic [2:0] {IDLE, ROW, COL, DRAIN, DONE} state_t;
    typedef struct packed {
        logic          vld;
        logic          axis;
        logic [IW-1:0] idx;
    } tag_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [XW-1:0] xc_q;
    logic [YW-1:0] yc_q;
    logic [1:0]    chan_q;
    logic [5:0]    thr_q;
    tag_t          tag_pipe [READ_LATENCY:0];
    tag_t          cur;
    logic          start_acc, in_range, pix_on, done_entry;
    logic [XW-1:0] row_lo, row_hi;
    logic [YW-1:0] col_lo, col_hi;
    logic          row_found, col_found;

    assign start_acc  = (state == IDLE) && find_corners_flag;
    assign in_range   = (int'(x_center) < WIDTH) && (int'(y_center) < HEIGHT);
    assign done_entry = (state != DONE) && (state_nxt == DONE);
    assign cur        = tag_pipe[READ_LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (find_corners_flag) state_nxt = in_range ? ROW : DONE;
            ROW:     if (cnt == CW'(WIDTH - 1)) state_nxt = COL;
            COL:     if (cnt == CW'(HEIGHT - 1)) state_nxt = DRAIN;
            DRAIN:   if (cnt == CW'(READ_LATENCY - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out       = (state == ROW) || (state == COL) || (state == DRAIN);
        data_valid_out = (state == DONE);
    end

    // Address generation; every issued address enters the tag pipe so the
    // returning pixel is classified by its own axis/index, not the current state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_out <= '0;
            cnt      <= '0;
            xc_q     <= '0;
            yc_q     <= '0;
            chan_q   <= '0;
            thr_q    <= '0;
            for (int k = 0; k <= READ_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0].vld <= 1'b0;
            for (int k = 1; k <= READ_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
            unique case (state)
                IDLE: if (find_corners_flag) begin
                    xc_q   <= x_center;
                    yc_q   <= y_center;
                    chan_q <= chan_sel;
                    thr_q  <= threshold;
                    cnt    <= '0;
                    if (in_range) begin
                        addr_out    <= AW'(y_center) * W_A;
                        tag_pipe[0] <= '{vld: 1'b1, axis: 1'b0, idx: '0};
                    end
                end
                ROW: if (cnt == CW'(WIDTH - 1)) begin
                    cnt         <= '0;
                    addr_out    <= AW'(xc_q);
                    tag_pipe[0] <= '{vld: 1'b1, axis: 1'b1, idx: '0};
                end else begin
                    cnt         <= cnt + CW'(1);
                    addr_out    <= addr_out + AW'(1);
                    tag_pipe[0] <= '{vld: 1'b1, axis: 1'b0, idx: IW'(cnt + CW'(1))};
                end
                COL: if (cnt == CW'(HEIGHT - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt         <= cnt + CW'(1);
                    addr_out    <= addr_out + W_A;
                    tag_pipe[0] <= '{vld: 1'b1, axis: 1'b1, idx: IW'(cnt + CW'(1))};
                end
                DRAIN:   cnt <= cnt + CW'(1);
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        pix_on = 1'b0;
        case (chan_q)
            2'd0:    pix_on = {1'b0, pixel_data_in[15:11]} >= thr_q;
            2'd1:    pix_on = pixel_data_in[10:5] >= thr_q;
            2'd2:    pix_on = {1'b0, pixel_data_in[4:0]} >= thr_q;
            default: pix_on = pixel_data_in != '0;
        endcase
    end

    find_corners_run_track #(.IW(XW), .GAP_TOL(GAP_TOL)) u_row (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr       (start_acc),
        .en        (cur.vld & ~cur.axis),
        .pix_on    (pix_on),
        .idx       (XW'(cur.idx)),
        .center    (xc_q),
        .lo_nxt    (row_lo),
        .hi_nxt    (row_hi),
        .found_nxt (row_found)
    );

    find_corners_run_track #(.IW(YW), .GAP_TOL(GAP_TOL)) u_col (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr       (start_acc),
        .en        (cur.vld & cur.axis),
        .pix_on    (pix_on),
        .idx       (YW'(cur.idx)),
        .center    (yc_q),
        .lo_nxt    (col_lo),
        .hi_nxt    (col_hi),
        .found_nxt (col_found)
    );

    // Entering DONE straight from IDLE means the center was out of frame.
    always_ff @(posedge clk_in) begin
        if (rst_in || (done_entry && state == IDLE)) begin
            left_edge  <= '0;
            right_edge <= '0;
            top_edge   <= '0;
            bot_edge   <= '0;
            found_x    <= 1'b0;
            found_y    <= 1'b0;
        end else if (done_entry) begin
            left_edge  <= row_lo;
            right_edge <= row_hi;
            top_edge   <= col_lo;
            bot_edge   <= col_hi;
            found_x    <= row_found;
            found_y    <= col_found;
        end
    end
endmodule

// File: tb/tb_find_corners_scan.sv
// Scoreboard bench: each start pushes the model's expected result; a monitor
// pops and compares whenever data_valid_out rises.

module tb_find_corners_scan;
    localparam int WIDTH  = 240;
    localparam int HEIGHT = 320;
    localparam int RL     = 2;
    localparam int GAP    = 2;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);
    localparam int AW     = $clog2(WIDTH * HEIGHT);
    localparam int MAXN   = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          find_corners_flag = 1'b0;
    logic [XW-1:0] x_center = '0;
    logic [YW-1:0] y_center = '0;
    logic [1:0]    chan_sel = '0;
    logic [5:0]    threshold = '0;
    logic [15:0]   pixel_data_in;
    logic [AW-1:0] addr_out;
    logic          busy_out, data_valid_out, found_x, found_y;
    logic [XW-1:0] left_edge, right_edge;
    logic [YW-1:0] top_edge, bot_edge;

    find_corners_scan #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .READ_LATENCY(RL), .GAP_TOL(GAP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .find_corners_flag(find_corners_flag),
        .x_center(x_center), .y_center(y_center), .chan_sel(chan_sel), .threshold(threshold),
        .pixel_data_in(pixel_data_in), .addr_out(addr_out), .busy_out(busy_out),
        .data_valid_out(data_valid_out), .left_edge(left_edge), .right_edge(right_edge),
        .top_edge(top_edge), .bot_edge(bot_edge), .found_x(found_x), .found_y(found_y)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Frame memory with a fixed read latency
    logic [15:0]   mem [WIDTH*HEIGHT];
    logic [AW-1:0] apipe [RL];
    always @(posedge clk_in) begin
        apipe[0] <= addr_out;
        for (int k = 1; k < RL; k++) apipe[k] <= apipe[k-1];
    end
    assign pixel_data_in = mem[int'(apipe[RL-1])];

    typedef struct { int l, r, t, b, fx, fy, cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit is_on(input logic [15:0] p, input int ch, input int th);
        case (ch)
            0:       return int'(p[15:11]) >= th;
            1:       return int'(p[10:5]) >= th;
            2:       return int'(p[4:0]) >= th;
            default: return p != 16'h0;
        endcase
    endfunction

    // Extent of the on-run through c, where gaps of up to GAP off pixels are bridged
    function automatic void line_model(input bit ln[MAXN], input int n, input int c,
                                       output int lo, output int hi, output int f);
        int last;
        lo = c; hi = c; f = 0;
        if (!ln[c]) return;
        f = 1;
        last = c;
        for (int i = c - 1; i >= 0; i--) begin
            if (ln[i]) begin lo = i; last = i; end
            else if (last - i > GAP) break;
        end
        last = c;
        for (int i = c + 1; i < n; i++) begin
            if (ln[i]) begin hi = i; last = i; end
            else if (i - last > GAP) break;
        end
    endfunction

    always @(negedge clk_in) begin
        if (data_valid_out) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("valid_cycle", cyc, mon_e.cyc);
                chk("busy_at_valid", int'(busy_out), 0);
                chk("left_edge", int'(left_edge), mon_e.l);
                chk("right_edge", int'(right_edge), mon_e.r);
                chk("top_edge", int'(top_edge), mon_e.t);
                chk("bot_edge", int'(bot_edge), mon_e.b);
                chk("found_x", int'(found_x), mon_e.fx);
                chk("found_y", int'(found_y), mon_e.fy);
            end
        end
    end

    task automatic start_scan(input int xc, input int yc, input int ch, input int th, input bit push);
        exp_t e;
        bit lr[MAXN];
        bit lc[MAXN];
        @(negedge clk_in);
        if (push) begin
            if (xc >= WIDTH || yc >= HEIGHT) begin
                e = '{0, 0, 0, 0, 0, 0, cyc + 1};
            end else begin
                for (int i = 0; i < MAXN; i++) begin lr[i] = 0; lc[i] = 0; end
                for (int x = 0; x < WIDTH; x++) lr[x] = is_on(mem[yc*WIDTH + x], ch, th);
                for (int y = 0; y < HEIGHT; y++) lc[y] = is_on(mem[y*WIDTH + xc], ch, th);
                line_model(lr, WIDTH, xc, e.l, e.r, e.fx);
                line_model(lc, HEIGHT, yc, e.t, e.b, e.fy);
                e.cyc = cyc + WIDTH + HEIGHT + RL + 1;
            end
            sb.push_back(e);
        end
        x_center = XW'(xc); y_center = YW'(yc); chan_sel = 2'(ch); threshold = 6'(th);
        find_corners_flag = 1'b1;
        @(negedge clk_in);
        find_corners_flag = 1'b0;
        x_center = XW'($urandom); y_center = YW'($urandom);
        chan_sel = 2'($urandom); threshold = 6'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin @(negedge clk_in); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic clear_lines(input int xc, input int yc);
        for (int x = 0; x < WIDTH; x++) mem[yc*WIDTH + x] = 16'h0;
        for (int y = 0; y < HEIGHT; y++) mem[y*WIDTH + xc] = 16'h0;
    endtask

    task automatic set_row(input int yc, input int a, input int b, input logic [15:0] v);
        for (int x = a; x <= b; x++) mem[yc*WIDTH + x] = v;
    endtask

    task automatic set_col(input int xc, input int a, input int b, input logic [15:0] v);
        for (int y = a; y <= b; y++) mem[y*WIDTH + xc] = v;
    endtask

    task automatic rand_lines(input int xc, input int yc);
        bit m = 0;
        for (int x = 0; x < WIDTH; x++) begin
            if ($urandom_range(0, 5) == 0) m = ~m;
            mem[yc*WIDTH + x] = m ? 16'($urandom | 32'h8410)
                                  : (($urandom_range(0, 3) == 0) ? 16'($urandom & 32'h7BEF) : 16'h0);
        end
        m = 0;
        for (int y = 0; y < HEIGHT; y++) begin
            if ($urandom_range(0, 5) == 0) m = ~m;
            mem[y*WIDTH + xc] = m ? 16'($urandom | 32'h8410)
                                  : (($urandom_range(0, 3) == 0) ? 16'($urandom & 32'h7BEF) : 16'h0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, int'(addr_out), 0);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_valid"}, int'(data_valid_out), 0);
        chk({tag, "_edges"}, int'(left_edge) + int'(right_edge) + int'(top_edge) + int'(bot_edge), 0);
        chk({tag, "_found"}, int'(found_x) + int'(found_y), 0);
    endtask

    initial begin
        for (int i = 0; i < WIDTH*HEIGHT; i++) mem[i] = 16'h0;
        repeat (3) @(negedge clk_in);
        check_zero("reset");
        rst_in = 1'b0;

        // Main pattern, start right after reset release, with address timing probes
        clear_lines(117, 161);
        mem[161*WIDTH] = 16'hFFFF;
        set_row(161, 80, 159, 16'hFFFF);
        mem[117] = 16'hFFFF;
        set_col(117, 80, 239, 16'hFFFF);
        start_scan(117, 161, 3, 0, 1);
        chk("busy_t1", int'(busy_out), 1);
        chk("addr_row_first", int'(addr_out), 161*WIDTH);
        repeat (WIDTH - 1) @(negedge clk_in);
        chk("addr_row_last", int'(addr_out), 161*WIDTH + WIDTH - 1);
        @(negedge clk_in);
        chk("addr_col_first", int'(addr_out), 117);
        repeat (HEIGHT - 1) @(negedge clk_in);
        chk("addr_col_last", int'(addr_out), (HEIGHT-1)*WIDTH + 117);
        @(negedge clk_in);
        chk("addr_drain_hold", int'(addr_out), (HEIGHT-1)*WIDTH + 117);
        chk("busy_drain", int'(busy_out), 1);
        wait_done(700);

        // Gap tolerance: bridged gap, then a gap one too long
        clear_lines(117, 161);
        set_row(161, 100, 110, 16'h1234);
        set_row(161, 113, 130, 16'h1234);
        set_col(117, 150, 170, 16'h0001);
        start_scan(117, 161, 3, 0, 1);
        wait_done(700);
        set_row(161, 111, 113, 16'h0);
        start_scan(117, 161, 3, 0, 1);
        wait_done(700);

        // Center pixel off
        clear_lines(117, 161);
        set_col(117, 150, 170, 16'h0001);
        set_row(161, 100, 130, 16'h0F00);
        mem[161*WIDTH + 117] = 16'h0;
        start_scan(117, 161, 3, 0, 1);
        wait_done(700);

        // Channel selection on 16'h00FF
        clear_lines(117, 161);
        set_row(161, 110, 125, 16'h00FF);
        set_col(117, 155, 165, 16'h00FF);
        start_scan(117, 161, 0, 1, 1);
        wait_done(700);
        start_scan(117, 161, 2, 31, 1);
        wait_done(700);
        start_scan(117, 161, 1, 8, 1);
        wait_done(700);

        // Reset mid-scan, then restart
        start_scan(117, 161, 2, 31, 0);
        repeat (99) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_zero("midscan_reset");
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("no_valid_after_reset", int'(data_valid_out), 0);
        start_scan(117, 161, 2, 31, 1);
        wait_done(700);

        // Start pulse during a scan is ignored
        rand_lines(100, 200);
        start_scan(100, 200, 3, 0, 1);
        repeat (49) @(negedge clk_in);
        x_center = XW'(5); y_center = YW'(7);
        find_corners_flag = 1'b1;
        @(negedge clk_in);
        find_corners_flag = 1'b0;
        wait_done(700);
        repeat (600) @(negedge clk_in);

        // Out-of-frame centers
        start_scan(WIDTH, 10, 3, 0, 1);
        wait_done(10);
        start_scan(10, HEIGHT, 3, 0, 1);
        wait_done(10);

        for (int n = 0; n < 12; n++) begin
            int xc, yc;
            xc = $urandom_range(0, WIDTH - 1);
            yc = $urandom_range(0, HEIGHT - 1);
            rand_lines(xc, yc);
            if (n % 6 == 5) xc = $urandom_range(WIDTH, (1 << XW) - 1);
            start_scan(xc, yc, $urandom_range(0, 3), $urandom_range(0, 40), 1);
            wait_done(700);
        end

        repeat (5) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
